// File: rtl/fp_alu_pkg.sv
// Shared definitions for the sequential floating-point ALU: op codes,
// FSM states and width-dependent constant helpers.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADDSUB, MULT, NORM, DONE
  } state_e;

  // Exponent bias, 2^(EXP_W-1)-1.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // All-ones biased exponent (inf/NaN), 2^EXP_W-1.
  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  // Returned in 64 bits; callers keep the low 1+EXP_W+MAN_W bits.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_alu_seq_if.sv
// Valid/ready operand and result bus of the floating-point ALU.
interface fp_alu_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_norm_pack.sv
// Combinational normaliser: finds the leading one of a fixed-point mantissa
// whose hidden bit nominally sits at bit FP, rescales the exponent, saturates
// to inf / flushes to zero, and packs the truncated result.
module fp_norm_pack
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int NW    = 48,
  parameter int FP    = 46,
  parameter int EW    = 12
) (
  input  logic [NW-1:0]             mant_i,
  input  logic signed [EW-1:0]      exp_i,
  input  logic                      sign_i,
  output logic [EXP_W+MAN_W:0]      result_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);
  localparam int LW = $clog2(NW);
  localparam logic signed [EW-1:0] FP_S   = EW'(FP);
  localparam logic signed [EW-1:0] EMAX_S = EW'(fp_exp_max(EXP_W));
  localparam logic signed [EW-1:0] ZERO_S = '0;

  logic [LW-1:0]         lead;
  logic [NW-1:0]         shifted;
  logic signed [EW-1:0]  exp_adj;

  // Leading-one detect: highest set bit wins.
  always_comb begin
    lead = '0;
    for (int i = 0; i < NW; i++) begin
      if (mant_i[i]) lead = LW'(i);
    end
  end

  // Left-align the leading one, adjust exponent, then range-check and pack.
  always_comb begin
    shifted     = mant_i << (LW'(NW - 1) - lead);
    exp_adj     = exp_i + signed'(EW'(lead)) - FP_S;
    result_o    = {sign_i, exp_adj[EXP_W-1:0], shifted[NW-2 -: MAN_W]};
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (mant_i == '0) begin
      // Exact cancellation always gives +0.
      result_o = '0;
    end else if (exp_adj >= EMAX_S) begin
      result_o   = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      overflow_o = 1'b1;
    end else if (exp_adj <= ZERO_S) begin
      result_o    = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      underflow_o = 1'b1;
    end
  end
endmodule

// File: rtl/fp_alu_seq.sv
// Multi-cycle floating-point ADD/SUB/MUL with truncating rounding,
// special-value handling and valid/ready flow control on both sides.
module fp_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic       clk,
  input  logic       rst,
  fp_alu_seq_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;        // mantissa incl. hidden bit
  localparam int XW  = MAN_W + 4;        // aligned mantissa with 3 guard bits
  localparam int PW  = 2 * M;            // product / normaliser width
  localparam int EW  = EXP_W + 4;        // signed working exponent
  localparam int CW  = $clog2(MAN_W + 1);
  localparam logic [EXP_W-1:0] EMAX     = EXP_W'(fp_exp_max(EXP_W));
  localparam logic [63:0]      NAN_FULL = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]     NAN_W    = NAN_FULL[W-1:0];

  state_e               state_q;
  logic                 in_ready_q, out_valid_q;
  logic [W-1:0]         result_q;
  logic                 ovf_q, unf_q, inv_q;
  logic [W-1:0]         a_q, b_q;
  logic [1:0]           op_q;
  logic                 sa_q, sb_q, sign_q, sub_q;
  logic [EXP_W-1:0]     ea_q, eb_q;
  logic [M-1:0]         ma_q, mb_q;
  logic [XW-1:0]        mx_q, my_q;
  logic [PW-1:0]        prod_q, prod_d;
  logic signed [EW-1:0] exp_q;
  logic [CW-1:0]        cnt_q;

  // Unpacked view of the captured operands (denormals count as zero).
  logic sa_u, sb_u, sb_eff, is_mul;
  logic [EXP_W-1:0] ea_u, eb_u;
  logic [MAN_W-1:0] fa_u, fb_u;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa_u, ea_u, fa_u} = a_q;
  assign {sb_u, eb_u, fb_u} = b_q;
  assign is_mul = (op_q == OP_MUL);
  assign sb_eff = sb_u ^ (op_q == OP_SUB);
  assign a_zero = (ea_u == '0);
  assign b_zero = (eb_u == '0);
  assign a_inf  = (ea_u == EMAX) && (fa_u == '0);
  assign b_inf  = (eb_u == EMAX) && (fb_u == '0);
  assign a_nan  = (ea_u == EMAX) && (fa_u != '0);
  assign b_nan  = (eb_u == EMAX) && (fb_u != '0);

  logic         spec_hit, spec_inv;
  logic [W-1:0] spec_res;

  // Special-value resolution; a hit bypasses the arithmetic datapath.
  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = NAN_W;
    if (is_mul) begin
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) spec_inv = 1'b1;
      else if (a_inf || b_inf)   spec_res = {sa_u ^ sb_eff, EMAX, {MAN_W{1'b0}}};
      else if (a_zero || b_zero) spec_res = {sa_u ^ sb_eff, {(W-1){1'b0}}};
      else                       spec_hit = 1'b0;
    end else begin
      if (a_nan || b_nan || (a_inf && b_inf && (sa_u != sb_eff))) spec_inv = 1'b1;
      else if (a_inf)  spec_res = {sa_u, EMAX, {MAN_W{1'b0}}};
      else if (b_inf)  spec_res = {sb_eff, EMAX, {MAN_W{1'b0}}};
      else if (a_zero) spec_res = b_zero ? {sb_eff, {(W-1){1'b0}}} : {sb_eff, eb_u, fb_u};
      else if (b_zero) spec_res = a_q;
      else             spec_hit = 1'b0;
    end
  end

  // Magnitude ordering and alignment shift; lost bits fold into a sticky LSB.
  logic             a_ge_b, s_big, sticky;
  logic [EXP_W-1:0] e_big, e_small, diff;
  logic [M-1:0]     m_big, m_small;
  logic [XW-1:0]    small_ext, small_sh;
  int               sh;

  always_comb begin
    a_ge_b    = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big     = a_ge_b ? ea_q : eb_q;
    e_small   = a_ge_b ? eb_q : ea_q;
    m_big     = a_ge_b ? ma_q : mb_q;
    m_small   = a_ge_b ? mb_q : ma_q;
    s_big     = a_ge_b ? sa_q : sb_q;
    diff      = e_big - e_small;
    sh        = (int'(diff) > MAN_W + 3) ? MAN_W + 3 : int'(diff);
    small_ext = {m_small, 3'b000};
    small_sh  = small_ext >> sh;
    sticky    = (small_sh << sh) != small_ext;
  end

  logic [XW:0] sum;
  assign sum = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier bit (LSB of the lower half) is set, then shift right.
  logic [M:0] mstep;
  assign mstep  = {1'b0, prod_q[PW-1:M]} + (prod_q[0] ? {1'b0, ma_q} : {(M+1){1'b0}});
  assign prod_d = {mstep, prod_q[M-1:1]};

  logic [W-1:0] norm_res;
  logic         norm_ovf, norm_unf;

  fp_norm_pack #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .NW(PW), .FP(2 * MAN_W), .EW(EW)
  ) u_norm (
    .mant_i(prod_q), .exp_i(exp_q), .sign_i(sign_q),
    .result_o(norm_res), .overflow_o(norm_ovf), .underflow_o(norm_unf)
  );

  // Control FSM and datapath registers, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q        <= bus.a;
          b_q        <= bus.b;
          op_q       <= bus.op;
          in_ready_q <= 1'b0;
          state_q    <= UNPACK;
        end
        UNPACK: begin
          sa_q <= sa_u;
          sb_q <= sb_eff;
          ea_q <= ea_u;
          eb_q <= eb_u;
          ma_q <= {1'b1, fa_u};
          mb_q <= {1'b1, fb_u};
          if (spec_hit) begin
            result_q    <= spec_res;
            inv_q       <= spec_inv;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (is_mul) begin
            exp_q   <= EW'(ea_u) + EW'(eb_u) - EW'(fp_bias(EXP_W));
            sign_q  <= sa_u ^ sb_eff;
            prod_q  <= {{M{1'b0}}, 1'b1, fb_u};
            cnt_q   <= '0;
            state_q <= MULT;
          end else begin
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          mx_q    <= {m_big, 3'b000};
          my_q    <= small_sh | XW'(sticky);
          exp_q   <= EW'(e_big);
          sign_q  <= s_big;
          sub_q   <= sa_q ^ sb_q;
          state_q <= ADDSUB;
        end
        ADDSUB: begin
          // Hidden bit moves from bit MAN_W+3 to bit 2*MAN_W, matching MUL.
          prod_q  <= PW'(sum) << (MAN_W - 3);
          state_q <= NORM;
        end
        MULT: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(MAN_W)) state_q <= NORM;
        end
        NORM: begin
          result_q    <= norm_res;
          ovf_q       <= norm_ovf;
          unf_q       <= norm_unf;
          inv_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.invalid   = inv_q;
endmodule

// File: doc/fp_alu_seq.md
Name: fp_alu_seq

Overview:
Multi-cycle, parametrised IEEE-754-style floating-point ALU. Supports ADD, SUB and MUL with special-value handling, overflow, underflow and invalid flags. Uses a valid/ready handshake on both the input and the output. Successor to the combinational add/multiply ALU, generalised in exponent/mantissa width, with a sequential shift-add multiplier and backpressure support.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 23, stored mantissa width (hidden bit excluded).
W, 1+EXP_W+MAN_W, total operand width (derived, not overridable).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept
a  in  W  operand A
b  in  W  operand B
op  in  2  00 ADD, 01 SUB (a-b), 10 MUL, 11 reserved (treated as ADD)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
result  out  W  packed result
overflow  out  1  result saturated to ±inf
underflow  out  1  result flushed to ±0
invalid  out  1  NaN produced

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; in_ready=1; out_valid=0; result=0; overflow=underflow=invalid=0; multiply counter=0. Reset mid-operation aborts the operation with no output.
- One operation in flight at a time. in_ready=1 only in IDLE. Transfer occurs when in_valid&in_ready; a, b, op are registered at that edge (cycle T).
- FSM: IDLE -> UNPACK -> (special ? DONE : ADD/SUB ? ALIGN -> ADDSUB -> NORM : MULT -> NORM) -> DONE -> IDLE.
- UNPACK: split sign/exp/mantissa and prepend the hidden bit. Denormal inputs (exp=0) are treated as ±0.
- Special cases, resolved in UNPACK and sent straight to DONE:
  - Any NaN input, inf-inf (effective subtraction), or 0*inf -> 0x7FC00000-style canonical NaN (sign 0, exp all ones, mantissa MSB 1), invalid=1.
  - inf op finite -> correctly signed inf, no flag.
  - Zero operand: ADD/SUB returns the other operand (sign-adjusted for SUB); MUL returns ±0 with sign a^b.
- ALIGN: order the operands by magnitude. Right-shift the smaller mantissa by the exponent difference, saturating at MAN_W+3. Carry 3 extra low bits (guard/round/sticky) that are discarded by truncation.
- ADDSUB: add or subtract magnitudes using effective sign (op SUB flips b's sign). Exact cancellation yields +0.
- MULT: shift-add over MAN_W+1 cycles using a counter from 0 to MAN_W. Produces a 2*(MAN_W+1)-bit product. Exponent = ea+eb-bias; sign = sa^sb.
- NORM: leading-one detect, left/right shift to restore the hidden bit, exponent adjust. Rounding is truncate (round toward zero).
  - Biased exp >= 2^EXP_W-1 -> ±inf, overflow=1.
  - Biased exp <= 0 -> ±0, underflow=1.
- DONE: out_valid=1. result and flags are stable while out_valid&!out_ready. On out_valid&out_ready, go to IDLE and clear out_valid. in_ready rises the next cycle, so there is no same-cycle accept.
- Latency, out_valid first high:
  - ADD/SUB: T+5.
  - MUL: T+MAN_W+4 (T+27 at default).
  - Special case: T+2.
- Flags are valid only while out_valid=1 and are held until handshake.

Decomposition:
- Package fp_alu_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_MUL;
  - state enum (IDLE, UNPACK, ALIGN, ADDSUB, MULT, NORM, DONE);
  - BIAS = 2^(EXP_W-1)-1;
  - EXP_MAX = 2^EXP_W-1;
  - canonical-NaN constant builder.
- Sub-module fp_norm_pack (combinational): leading-one detect, normalising shift, exponent adjust, overflow/underflow detect, pack. Instantiated once and registered in NORM.

Test Plan:
1. ADD 0x3F800000 + 0x40000000 (1.0+2.0), out_ready=1 -> result 0x40400000 at T+5, all flags 0.
2. MUL 0x3FC00000 * 0x40000000 (1.5*2.0) -> result 0x40400000 at T+27, flags 0. in_ready stays 0 throughout.
3. SUB 0x40400000 - 0x40400000 -> 0x00000000, flags 0. ADD 0x3F800000 + 0x33800000 (1.0+2^-24) -> 0x3F800000 (truncation).
4. MUL 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1. MUL 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
5. SUB 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1 at T+2. MUL 0x00000000 * 0xFF800000 -> 0x7FC00000, invalid=1.
6. Hold out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0. Assert rst during MULT cycle 10 -> next cycle out_valid=0, in_ready=1, no spurious output. Also repeat scenario 1 with EXP_W=5, MAN_W=10: 0x3C00+0x4000 -> 0x4200.
